mem_axil_bridge: RTL and testbench

Downstream companion of the `riscv` core: converts the core's picorv32-style native memory request (`mem_valid`/`mem_ready`) into single AXI4-Lite master transactions and returns the result. One request is outstanding at a time. Instruction fetches, loads and stores all pass through it. AXI protection bits and response codes are mapped here, so the core never sees raw AXI.

---
 rtl/mem_axil_bridge.sv | 209 ++++++++++++++++++++
 tb/tb_mem_axil_bridge.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_axil_bridge.sv
// mem_axil_bridge: turns one picorv32-style native memory request at a time
// into a single AXI4-Lite read or write, then returns data and an error flag.
// Every output is a flop; next values are computed from the next state.
module mem_axil_bridge (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        mem_error,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] awaddr,
  output logic [2:0]  awprot,
  output logic        wvalid,
  input  logic        wready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  input  logic        bvalid,
  output logic        bready,
  input  logic [1:0]  bresp,
  output logic        arvalid,
  input  logic        arready,
  output logic [31:0] araddr,
  output logic [2:0]  arprot,
  input  logic        rvalid,
  output logic        rready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_REQ  = 3'd3,
    WR_RESP = 3'd4,
    DONE    = 3'd5
  } state_e;

  // SLVERR and DECERR are failures; OKAY and EXOKAY are success.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == 2'b10) || (resp == 2'b11);
  endfunction

  state_e      state_q, state_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic        bready_q, bready_d;
  logic        mem_ready_q, mem_ready_d;
  logic        mem_error_q, mem_error_d;
  logic [31:0] araddr_q, araddr_d;
  logic [31:0] awaddr_q, awaddr_d;
  logic [2:0]  arprot_q, arprot_d;
  logic [2:0]  awprot_q, awprot_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;
  logic        accept_s;
  logic        unused_addr_bits;

  // The bus is word addressed, so the byte offset is dropped.
  assign unused_addr_bits = ^mem_addr[1:0];
  assign accept_s         = (state_q == IDLE) && mem_valid;

  // State and all output registers; reset abandons any AXI transaction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      mem_ready_q <= 1'b0;
      mem_error_q <= 1'b0;
      araddr_q    <= 32'h0000_0000;
      awaddr_q    <= 32'h0000_0000;
      arprot_q    <= 3'b000;
      awprot_q    <= 3'b000;
      wdata_q     <= 32'h0000_0000;
      wstrb_q     <= 4'b0000;
      mem_rdata_q <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      mem_ready_q <= mem_ready_d;
      mem_error_q <= mem_error_d;
      araddr_q    <= araddr_d;
      awaddr_q    <= awaddr_d;
      arprot_q    <= arprot_d;
      awprot_q    <= awprot_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  // Next state, plus the per-channel write handshake flags.
  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (state_q)
      IDLE: begin
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        if (mem_valid) begin
          if (mem_wstrb == 4'b0000) begin
            state_d = RD_ADDR;
          end else begin
            state_d = WR_REQ;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RD_ADDR: begin
        if (arready) state_d = RD_DATA;
        else         state_d = RD_ADDR;
      end
      RD_DATA: begin
        if (rvalid) state_d = DONE;
        else        state_d = RD_DATA;
      end
      WR_REQ: begin
        aw_done_d = aw_done_q | (awvalid_q & awready);
        w_done_d  = w_done_q  | (wvalid_q & wready);
        if (aw_done_d && w_done_d) state_d = WR_RESP;
        else                       state_d = WR_REQ;
      end
      WR_RESP: begin
        if (bvalid) state_d = DONE;
        else        state_d = WR_RESP;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next output values: handshake strobes follow the next state, payloads
  // load once at acceptance and hold until the next request.
  always_comb begin
    arvalid_d   = (state_d == RD_ADDR);
    rready_d    = (state_d == RD_DATA);
    awvalid_d   = (state_d == WR_REQ) && !aw_done_d;
    wvalid_d    = (state_d == WR_REQ) && !w_done_d;
    bready_d    = (state_d == WR_RESP);
    mem_ready_d = (state_d == DONE);
    mem_error_d = 1'b0;
    mem_rdata_d = mem_rdata_q;
    araddr_d    = araddr_q;
    awaddr_d    = awaddr_q;
    arprot_d    = arprot_q;
    awprot_d    = awprot_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    if (accept_s) begin
      if (mem_wstrb == 4'b0000) begin
        araddr_d = {mem_addr[31:2], 2'b00};
        arprot_d = mem_instr ? 3'b101 : 3'b000;
      end else begin
        awaddr_d = {mem_addr[31:2], 2'b00};
        awprot_d = mem_instr ? 3'b101 : 3'b000;
        wdata_d  = mem_wdata;
        wstrb_d  = mem_wstrb;
      end
    end else if ((state_q == RD_DATA) && rvalid) begin
      mem_error_d = resp_is_err(rresp);
      mem_rdata_d = resp_is_err(rresp) ? 32'h0000_0000 : rdata;
    end else if ((state_q == WR_RESP) && bvalid) begin
      mem_error_d = resp_is_err(bresp);
    end else begin
      mem_error_d = 1'b0;
    end
  end

  assign arvalid   = arvalid_q;
  assign araddr    = araddr_q;
  assign arprot    = arprot_q;
  assign rready    = rready_q;
  assign awvalid   = awvalid_q;
  assign awaddr    = awaddr_q;
  assign awprot    = awprot_q;
  assign wvalid    = wvalid_q;
  assign wdata     = wdata_q;
  assign wstrb     = wstrb_q;
  assign bready    = bready_q;
  assign mem_ready = mem_ready_q;
  assign mem_rdata = mem_rdata_q;
  assign mem_error = mem_error_q;

endmodule

// File: tb/tb_mem_axil_bridge.sv
// Bench for mem_axil_bridge: a configurable-latency AXI4-Lite slave, a
// requester task, and a transaction-level model of the expected results.
`timescale 1ns/1ps
module tb_mem_axil_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_valid, mem_instr;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready, mem_error;
  logic [31:0] mem_rdata;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  int checks = 0;
  int failures = 0;

  // slave configuration, set per transaction
  int ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0, b_wait = 0;
  logic [31:0] s_rdata = 32'h0;
  logic [1:0]  s_rresp = 2'b00, s_bresp = 2'b00;

  // slave internal state and observations
  int ar_cnt, aw_cnt, w_cnt, r_cnt, b_cnt;
  logic aw_got, w_got;
  logic [31:0] cap_araddr, cap_awaddr, cap_wdata;
  logic [2:0]  cap_arprot, cap_awprot;
  logic [3:0]  cap_wstrb;
  int n_ar = 0, n_aw = 0, n_w = 0, n_r = 0, n_b = 0, n_ready = 0, viol = 0;
  logic p_ar_stall, p_aw_stall, p_w_stall, p_mem_ready;
  logic [31:0] p_araddr, p_awaddr, p_wdata;
  logic [2:0]  p_arprot, p_awprot;
  logic [3:0]  p_wstrb;

  logic [31:0] model_rdata = 32'h0;
  int          n_req = 0;

  logic ar_hs, aw_hs, w_hs;
  assign ar_hs   = arvalid && arready;
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;
  assign arready = arvalid && (ar_cnt >= ar_wait);
  assign awready = awvalid && (aw_cnt >= aw_wait);
  assign wready  = wvalid && (w_cnt >= w_wait);

  mem_axil_bridge dut (
    .clk(clk), .reset(reset),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .mem_error(mem_error),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
  );

  always #5 clk = ~clk;

  // AXI4-Lite slave with programmable ready and response delays
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      ar_cnt <= 0; aw_cnt <= 0; w_cnt <= 0; r_cnt <= 0; b_cnt <= 0;
      aw_got <= 1'b0; w_got <= 1'b0;
      rvalid <= 1'b0; rdata <= 32'h0; rresp <= 2'b00;
      bvalid <= 1'b0; bresp <= 2'b00;
    end else begin
      ar_cnt <= (arvalid && !arready) ? ar_cnt + 1 : 0;
      aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (wvalid && !wready) ? w_cnt + 1 : 0;
      if (ar_hs) begin
        cap_araddr <= araddr; cap_arprot <= arprot; n_ar <= n_ar + 1;
        if (r_wait == 0) begin rvalid <= 1'b1; rdata <= s_rdata; rresp <= s_rresp; end
        else r_cnt <= r_wait;
      end else if (r_cnt > 0) begin
        r_cnt <= r_cnt - 1;
        if (r_cnt == 1) begin rvalid <= 1'b1; rdata <= s_rdata; rresp <= s_rresp; end
      end else if (rvalid && rready) begin
        rvalid <= 1'b0; n_r <= n_r + 1;
      end
      if (aw_hs) begin cap_awaddr <= awaddr; cap_awprot <= awprot; n_aw <= n_aw + 1; end
      if (w_hs) begin cap_wdata <= wdata; cap_wstrb <= wstrb; n_w <= n_w + 1; end
      if ((aw_got || aw_hs) && (w_got || w_hs)) begin
        aw_got <= 1'b0; w_got <= 1'b0;
        if (b_wait == 0) begin bvalid <= 1'b1; bresp <= s_bresp; end
        else b_cnt <= b_wait;
      end else begin
        aw_got <= aw_got || aw_hs;
        w_got  <= w_got || w_hs;
        if (b_cnt > 0) begin
          b_cnt <= b_cnt - 1;
          if (b_cnt == 1) begin bvalid <= 1'b1; bresp <= s_bresp; end
        end else if (bvalid && bready) begin
          bvalid <= 1'b0; n_b <= n_b + 1;
        end
      end
    end
  end

  // protocol watcher: valid/payload stability, one-cycle mem_ready, bready timing
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      p_ar_stall <= 1'b0; p_aw_stall <= 1'b0; p_w_stall <= 1'b0; p_mem_ready <= 1'b0;
    end else begin
      viol <= viol
        + ((p_ar_stall && (!arvalid || araddr !== p_araddr || arprot !== p_arprot)) ? 1 : 0)
        + ((p_aw_stall && (!awvalid || awaddr !== p_awaddr || awprot !== p_awprot)) ? 1 : 0)
        + ((p_w_stall && (!wvalid || wdata !== p_wdata || wstrb !== p_wstrb)) ? 1 : 0)
        + ((p_mem_ready && mem_ready) ? 1 : 0)
        + ((bready && (awvalid || wvalid)) ? 1 : 0);
      n_ready     <= n_ready + (mem_ready ? 1 : 0);
      p_ar_stall  <= arvalid && !arready;
      p_aw_stall  <= awvalid && !awready;
      p_w_stall   <= wvalid && !wready;
      p_mem_ready <= mem_ready;
      p_araddr <= araddr; p_arprot <= arprot;
      p_awaddr <= awaddr; p_awprot <= awprot;
      p_wdata  <= wdata;  p_wstrb  <= wstrb;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Core-side requester: raise, scramble inputs after acceptance, wait for
  // mem_ready, drop mem_valid on the edge that samples it.
  task automatic do_req(input logic instr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] ws, output int lat, output logic [31:0] rd,
                        output logic err);
    mem_valid = 1'b1; mem_instr = instr; mem_addr = addr; mem_wdata = wd; mem_wstrb = ws;
    lat = 0; rd = 32'h0; err = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) begin
        mem_addr = $urandom; mem_wdata = $urandom;
        mem_wstrb = 4'($urandom); mem_instr = 1'($urandom);
      end
      if (mem_ready === 1'b1) begin
        rd = mem_rdata; err = mem_error;
        break;
      end
    end
    chk("completed", 64'(mem_ready), 64'd1);
    @(posedge clk); #1;
    mem_valid = 1'b0;
    chk("ready_one_cycle", 64'(mem_ready), 64'd0);
  endtask

  // One transaction against the slave settings, checked against the model.
  task automatic run(input logic instr, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [3:0] ws, input int aww, input int ww, input int arw,
                     input int rw, input int bw, input logic [31:0] rdat, input logic [1:0] resp);
    int lat, exp_lat;
    int ar0, aw0, w0, r0, b0, rdy0;
    logic [31:0] rd, exp_rd;
    logic err;
    logic is_wr;
    is_wr = (ws != 4'b0000);
    aw_wait = aww; w_wait = ww; ar_wait = arw; r_wait = rw; b_wait = bw;
    s_rdata = rdat; s_rresp = resp; s_bresp = resp;
    ar0 = n_ar; aw0 = n_aw; w0 = n_w; r0 = n_r; b0 = n_b; rdy0 = n_ready;
    if (is_wr) begin
      exp_lat = 3 + ((aww > ww) ? aww : ww) + bw;
      exp_rd  = model_rdata;
    end else begin
      exp_lat = 3 + arw + rw;
      exp_rd  = (resp >= 2'd2) ? 32'h0 : rdat;
    end
    model_rdata = exp_rd;
    n_req++;
    do_req(instr, addr, wd, ws, lat, rd, err);
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("mem_rdata", 64'(rd), 64'(exp_rd));
    chk("mem_error", 64'(err), 64'(resp >= 2'd2));
    chk("ready_pulses", 64'(n_ready - rdy0), 64'd1);
    if (is_wr) begin
      chk("awaddr", 64'(cap_awaddr), 64'(addr & 32'hFFFF_FFFC));
      chk("awprot", 64'(cap_awprot), instr ? 64'd5 : 64'd0);
      chk("wdata", 64'(cap_wdata), 64'(wd));
      chk("wstrb", 64'(cap_wstrb), 64'(ws));
      chk("aw_count", 64'(n_aw - aw0), 64'd1);
      chk("w_count", 64'(n_w - w0), 64'd1);
      chk("b_count", 64'(n_b - b0), 64'd1);
      chk("no_read", 64'(n_ar - ar0), 64'd0);
    end else begin
      chk("araddr", 64'(cap_araddr), 64'(addr & 32'hFFFF_FFFC));
      chk("arprot", 64'(cap_arprot), instr ? 64'd5 : 64'd0);
      chk("ar_count", 64'(n_ar - ar0), 64'd1);
      chk("r_count", 64'(n_r - r0), 64'd1);
      chk("no_write", 64'(n_aw - aw0), 64'd0);
    end
  endtask

  initial begin
    reset = 1'b0;
    mem_valid = 1'b0; mem_instr = 1'b0; mem_addr = 32'h0; mem_wdata = 32'h0; mem_wstrb = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 64'(|{awvalid, wvalid, arvalid, rready, bready, mem_ready, mem_error,
        awaddr, araddr, wdata, wstrb, awprot, arprot, mem_rdata}), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // zero-wait instruction fetch
    run(1'b1, 32'h0000_0104, 32'h0, 4'b0000, 0, 0, 0, 0, 0, 32'h0000_0013, 2'b00);
    // stalled data load: arready low 3 cycles, rvalid 2 more
    run(1'b0, 32'h2000_0008, 32'h0, 4'b0000, 0, 0, 3, 2, 0, 32'hCAFE_0001, 2'b00);
    // split write: wready first, awready 3 cycles later
    run(1'b0, 32'h1000_0010, 32'hDEAD_BEEF, 4'b0011, 3, 0, 0, 0, 0, 32'h0, 2'b00);
    // reverse order write with a slow response, EXOKAY
    run(1'b0, 32'h1000_0022, 32'h1234_5678, 4'b1100, 0, 2, 0, 0, 2, 32'h0, 2'b01);
    // error responses, then a clean read
    run(1'b0, 32'h3000_0004, 32'h0, 4'b0000, 0, 0, 0, 0, 0, 32'hFFFF_FFFF, 2'b10);
    run(1'b0, 32'h3000_0008, 32'h5555_AAAA, 4'b1111, 0, 0, 0, 0, 0, 32'h0, 2'b11);
    run(1'b0, 32'h2000_000B, 32'h0, 4'b0000, 0, 0, 1, 0, 0, 32'h0BAD_F00D, 2'b00);

    // reset while a write is stuck waiting for both ready signals
    aw_wait = 20; w_wait = 20;
    mem_valid = 1'b1; mem_instr = 1'b0; mem_addr = 32'h4000_0000;
    mem_wdata = 32'hA5A5_A5A5; mem_wstrb = 4'b1111;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_reset_awvalid", 64'(awvalid), 64'd1);
    reset = 1'b0;
    #1;
    chk("midop_reset_outputs", 64'(|{awvalid, wvalid, arvalid, rready, bready, mem_ready, mem_error,
        awaddr, araddr, wdata, wstrb, awprot, arprot, mem_rdata}), 64'd0);
    mem_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_rdata = 32'h0;
    run(1'b0, 32'h0000_0040, 32'h0, 4'b0000, 0, 0, 0, 0, 0, 32'h7777_0040, 2'b00);

    // randomized back-to-back traffic
    for (int k = 0; k < 24; k++) begin
      logic [3:0] ws;
      ws = ($urandom_range(1, 0) == 1) ? 4'($urandom_range(15, 1)) : 4'b0000;
      run(1'($urandom), $urandom, $urandom, ws,
          int'($urandom_range(3, 0)), int'($urandom_range(3, 0)),
          int'($urandom_range(3, 0)), int'($urandom_range(3, 0)),
          int'($urandom_range(3, 0)), $urandom, 2'($urandom));
    end

    repeat (2) @(posedge clk);
    #1;
    chk("protocol_violations", 64'(viol), 64'd0);
    chk("total_ready_pulses", 64'(n_ready), 64'(n_req));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
